// File: rtl/vedic_mult32_seq_pkg.sv
// rtl/vedic_mult32_seq_pkg.sv - shared types, widths and step shift table for the sequential 32x32 multiplier
package vedic_mult32_seq_pkg;

   localparam int W_IN   = 32;
   localparam int W_HALF = 16;
   localparam int W_OUT  = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Left shift applied to the partial product of each step.
   function automatic logic [5:0] step_shift(input logic [1:0] step);
      case (step)
         2'd0:    return 6'd0;
         2'd1:    return 6'd16;
         2'd2:    return 6'd16;
         default: return 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/vedic_mult32_seq_mul16.sv
// rtl/vedic_mult32_seq_mul16.sv - combinational 16x16 vedic (crosswise) multiplier
module vedic_mult32_seq_mul16
   import vedic_mult32_seq_pkg::*;
(
   input  logic [W_HALF-1:0]   x,
   input  logic [W_HALF-1:0]   y,
   output logic [2*W_HALF-1:0] p
);

   logic [15:0] p_ll;
   logic [15:0] p_lh;
   logic [15:0] p_hl;
   logic [15:0] p_hh;
   logic [16:0] p_mid;

   // Vertical and crosswise 8x8 products, then the crosswise pair lands at bit 8.
   always_comb begin
      p_ll  = {8'b0, x[7:0]}  * {8'b0, y[7:0]};
      p_lh  = {8'b0, x[7:0]}  * {8'b0, y[15:8]};
      p_hl  = {8'b0, x[15:8]} * {8'b0, y[7:0]};
      p_hh  = {8'b0, x[15:8]} * {8'b0, y[15:8]};
      p_mid = {1'b0, p_lh} + {1'b0, p_hl};
      p     = {p_hh, p_ll} + {7'b0, p_mid, 8'b0};
   end

endmodule

// File: rtl/vedic_mult32_seq.sv
// rtl/vedic_mult32_seq.sv - 32x32 unsigned multiplier time-sharing one 16x16 core over four steps
module vedic_mult32_seq
   import vedic_mult32_seq_pkg::*;
#(
   parameter int PP_REG = 0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  a,
   input  logic [W_IN-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] result,
   output logic             busy
);

   // With the product register the final accumulate happens one cycle after the last issue.
   localparam logic [2:0] LAST_STEP = (PP_REG != 0) ? 3'd4 : 3'd3;

   state_t               state_q;
   state_t               state_d;
   logic                 accept;
   logic [2:0]           step_q;
   logic [W_IN-1:0]      a_r;
   logic [W_IN-1:0]      b_r;
   logic [W_OUT-1:0]     acc_q;
   logic [W_HALF-1:0]    op_a;
   logic [W_HALF-1:0]    op_b;
   logic [2*W_HALF-1:0]  pp_comb;
   logic [2*W_HALF-1:0]  acc_pp;
   logic [1:0]           acc_sel;
   logic                 acc_en;
   logic [W_OUT-1:0]     addend;

   // Step bit 1 picks the high half of a, step bit 0 the high half of b.
   always_comb begin
      op_a = step_q[1] ? a_r[31:16] : a_r[15:0];
      op_b = step_q[0] ? b_r[31:16] : b_r[15:0];
   end

   vedic_mult32_seq_mul16 u_mul16 (
      .x (op_a),
      .y (op_b),
      .p (pp_comb)
   );

   generate
      if (PP_REG != 0) begin : g_pp_reg
         logic [2*W_HALF-1:0] pp_q;
         logic [1:0]          sel_q;

         // Product register; the step index travels with it to pick the shift.
         always_ff @(posedge clk) begin
            if (rst) begin
               pp_q  <= '0;
               sel_q <= '0;
            end else begin
               pp_q  <= pp_comb;
               sel_q <= step_q[1:0];
            end
         end

         assign acc_pp  = pp_q;
         assign acc_sel = sel_q;
         assign acc_en  = (state_q == ST_MUL) && (step_q != 3'd0);
      end else begin : g_pp_comb
         assign acc_pp  = pp_comb;
         assign acc_sel = step_q[1:0];
         assign acc_en  = (state_q == ST_MUL);
      end
   endgenerate

   assign addend = {32'b0, acc_pp} << step_shift(acc_sel);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; DONE can hand off straight into a new MUL.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            if (step_q == LAST_STEP) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               state_d = in_valid ? ST_MUL : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign accept = in_valid && in_ready;
   assign busy   = (state_q != ST_IDLE);
   assign result = acc_q;

   // Operand capture on accept, then step counting and accumulation while in MUL.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         acc_q  <= '0;
         step_q <= '0;
      end else if (accept) begin
         a_r    <= a;
         b_r    <= b;
         acc_q  <= '0;
         step_q <= '0;
      end else if (state_q == ST_MUL) begin
         step_q <= step_q + 3'd1;
         if (acc_en) begin
            acc_q <= acc_q + addend;
         end
      end
   end

endmodule

// File: tb/tb_vedic_mult32_seq.sv
// tb/tb_vedic_mult32_seq.sv - self-checking bench for vedic_mult32_seq
module tb_vedic_mult32_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        busy;

   logic        in_valid1;
   logic        in_ready1;
   logic [31:0] a1;
   logic [31:0] b1;
   logic        out_valid1;
   logic        out_ready1;
   logic [63:0] result1;
   logic        busy1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vedic_mult32_seq #(.PP_REG(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   vedic_mult32_seq #(.PP_REG(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .result    (result1),
      .busy      (busy1)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%h exp=0x%h", nm, got, exp);
      end
   endtask

   // Transaction-level model: idle / counting down / holding a result.
   localparam int LAT = 4;
   int          m_mode = 0;
   int          m_cnt  = 0;
   int          m_hs   = 0;
   bit          m_live = 1'b0;
   logic [63:0] m_pend = '0;
   logic [63:0] m_res  = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_live = 1'b1;
         m_mode = 0;
         m_res  = '0;
      end else if (m_live) begin
         case (m_mode)
            0: if (in_valid) begin
                  m_mode = 1; m_cnt = LAT; m_res = '0;
                  m_pend = {32'b0, a} * {32'b0, b};
               end
            1: begin
                  m_cnt--;
                  if (m_cnt == 0) begin m_mode = 2; m_res = m_pend; end
               end
            default: if (out_ready) begin
                  m_hs++;
                  if (in_valid) begin
                     m_mode = 1; m_cnt = LAT; m_res = '0;
                     m_pend = {32'b0, a} * {32'b0, b};
                  end else begin
                     m_mode = 0;
                  end
               end
         endcase
      end
   end

   int          hs_count = 0;
   logic [63:0] hs_res[$];
   time         hs_t[$];

   // Per-cycle comparison against the model, plus a log of result handshakes.
   always @(negedge clk) begin
      if (m_live) begin
         chk("in_ready", {63'b0, in_ready}, {63'b0, (m_mode == 0) || (m_mode == 2 && out_ready)});
         chk("out_valid", {63'b0, out_valid}, {63'b0, m_mode == 2});
         chk("busy", {63'b0, busy}, {63'b0, m_mode != 0});
         if (m_mode != 1) chk("result", result, m_res);
         if (!rst && out_valid && out_ready) begin
            hs_count++;
            hs_res.push_back(result);
            hs_t.push_back($time);
         end
      end
   end

   task automatic run_op(input logic [31:0] x, input logic [31:0] y, output int lat, output logic [63:0] r);
      a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1; r = '0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin lat = k; r = result; break; end
      end
      @(posedge clk); #1;
   endtask

   int          lat;
   logic [63:0] r;
   int          base;
   int          hs_before;
   logic [31:0] ra[4];
   logic [31:0] rb[4];

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_result", result, 64'd0);
      @(posedge clk); #1;

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, r);
      chk("basic_lat", 64'(lat), 64'd4);
      chk("basic_res", r, 64'hFFFF_FFFE_0000_0001);
      run_op(32'h0001_0000, 32'h0001_0000, lat, r);
      chk("shift_hh", r, 64'h0000_0001_0000_0000);
      run_op(32'h0000_FFFF, 32'hFFFF_0000, lat, r);
      chk("shift_cross", r, 64'h0000_FFFE_0001_0000);
      run_op(32'h0, 32'h1234_5678, lat, r);
      chk("zero", r, 64'd0);

      // Backpressure with toggling operands and in_valid held high.
      a = 32'h0002_0003; b = 32'h0004_0005; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 32'hFFFF_0000; b = 32'h1111_1111;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin lat = k; break; end
      end
      chk("bp_lat", 64'(lat), 64'd4);
      hs_before = hs_count;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         a = ~a; b = ~b;
         @(negedge clk);
         chk("bp_hold", result, 64'h0000_0008_0016_000F);
         chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
      end
      @(posedge clk); #1;
      a = 32'd7; b = 32'd9; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_handoff_busy", {63'b0, busy}, 64'd1);
      chk("bp_handoff_hs", 64'(hs_count - hs_before), 64'd1);
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         if (out_valid === 1'b1) begin lat = k; r = result; break; end
         @(negedge clk);
      end
      chk("bp_next_lat", 64'(lat), 64'd4);
      chk("bp_next_res", r, 64'd63);
      @(posedge clk); #1;

      // Back-to-back with in_valid and out_ready tied high.
      for (int i = 0; i < 4; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
      base = hs_res.size();
      in_valid = 1'b1; out_ready = 1'b1; a = ra[0]; b = rb[0];
      @(posedge clk); #1;
      for (int i = 1; i < 4; i++) begin
         a = ra[i]; b = rb[i];
         repeat (5) @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("b2b_count", 64'(hs_res.size() - base), 64'd4);
      if (hs_res.size() >= base + 4) begin
         for (int i = 0; i < 4; i++)
            chk("b2b_res", hs_res[base + i], {32'b0, ra[i]} * {32'b0, rb[i]});
         for (int i = 1; i < 4; i++)
            chk("b2b_spacing", 64'(hs_t[base + i] - hs_t[base + i - 1]), 64'd50);
      end

      // Reset during MUL step 2 aborts the transaction.
      a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
      chk("abort_busy", {63'b0, busy}, 64'd0);
      chk("abort_result", result, 64'd0);
      hs_before = hs_count;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_no_result", 64'(hs_count - hs_before), 64'd0);
      run_op(32'd3, 32'd5, lat, r);
      chk("after_abort_lat", 64'(lat), 64'd4);
      chk("after_abort_res", r, 64'd15);

      // Registered product variant: one extra cycle of latency.
      a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid1 === 1'b1) begin lat = k; r = result1; break; end
      end
      chk("pp_reg_lat", 64'(lat), 64'd5);
      chk("pp_reg_res", r, 64'hFFFF_FFFE_0000_0001);
      @(posedge clk); #1;
      a1 = 32'h0000_FFFF; b1 = 32'hFFFF_0000; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid1 === 1'b1) begin lat = k; r = result1; break; end
      end
      chk("pp_reg_lat2", 64'(lat), 64'd5);
      chk("pp_reg_res2", r, 64'h0000_FFFE_0001_0000);
      @(posedge clk); #1;

      chk("hs_total", 64'(hs_count), 64'(m_hs));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
